gyro_fir_filter: RTL and testbench

Parametrised, time-multiplexed FIR filter for the IMU gyro path: N channels of signed samples, a runtime-loadable coefficient bank, output rounding and saturation, and a bypass mode. It sits between the IMU read logic and the attitude/control logic. It generalises the fixed 3-axis, 10-tap high-pass filter into one shared multiply-accumulate engine. It uses a single clock with a valid/ready handshake.

---
 rtl/gyro_fir_filter_pkg.sv | 43 ++++
 rtl/gyro_fir_filter_if.sv | 33 +++
 rtl/gyro_fir_filter_mac.sv | 58 +++++
 rtl/gyro_fir_filter.sv | 159 +++++++++++++++
 tb/tb_gyro_fir_filter.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gyro_fir_filter_pkg.sv
// Shared definitions for the gyro FIR filter.
// - state_e       : sequencer states (IDLE, MAC, DONE)
// - DefaultCoefs  : reset-time coefficient set, 10 taps of Q1.15, tap 0 in
//                   the least significant 16 bits. The set sums to zero, so
//                   the filter rejects DC.
// - default_coef  : default value for any tap index (zero beyond tap 9)
// - round_sat     : round-half-up, arithmetic shift and clamp to a signed
//                   output range. Operates on 64-bit values so callers of any
//                   reasonable width can share it.
package gyro_filter_pkg;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_e;

  localparam int DefaultTaps = 10;

  localparam logic [DefaultTaps*16-1:0] DefaultCoefs = {
    16'h025b, 16'hf1ce, 16'h2ab5, 16'had13, 16'h71a8,
    16'h8e58, 16'h52ed, 16'hd54b, 16'h0e32, 16'hfda5
  };

  function automatic logic signed [15:0] default_coef(input int k);
    logic signed [15:0] c;
    c = '0;
    if (k < DefaultTaps) c = $signed(DefaultCoefs[k*16 +: 16]);
    return c;
  endfunction

  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input int frac,
                                                   input int out_w);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r = acc;
    if (frac > 0) r = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/gyro_fir_filter_if.sv
// Bus between the IMU read logic (master) and the gyro FIR filter (slave).
// Master drives: sample_valid, sample_in, bypass, coef_write, coef_addr,
//                coef_data, overrun_clear
// Slave drives : filtered_out, data_ready, busy, overrun
// sample_in/filtered_out pack channel c at [c*DataWidth +: DataWidth].
interface gyro_fir_filter_if #(
  parameter int DataWidth = 10,
  parameter int Channels  = 3,
  parameter int Taps      = 10,
  parameter int CoefWidth = 16
);
  logic                          sample_valid;
  logic [Channels*DataWidth-1:0] sample_in;
  logic                          bypass;
  logic                          coef_write;
  logic [$clog2(Taps)-1:0]       coef_addr;
  logic [CoefWidth-1:0]          coef_data;
  logic                          overrun_clear;
  logic [Channels*DataWidth-1:0] filtered_out;
  logic                          data_ready;
  logic                          busy;
  logic                          overrun;

  modport master (
    output sample_valid, sample_in, bypass, coef_write, coef_addr, coef_data, overrun_clear,
    input  filtered_out, data_ready, busy, overrun
  );

  modport slave (
    input  sample_valid, sample_in, bypass, coef_write, coef_addr, coef_data, overrun_clear,
    output filtered_out, data_ready, busy, overrun
  );
endinterface

// File: rtl/gyro_fir_filter_mac.sv
// Shared multiply-accumulate engine for the gyro FIR filter.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr_i        : clear the accumulator (start of a new sample set)
//   en_i         : a product is presented this cycle
//   last_i       : this product is the last tap of the current channel
//   coef_i       : coefficient for the current tap
//   sample_i     : delay-line sample for the current channel/tap
//   result_o     : rounded, saturated (acc + product); valid when en_i&last_i
module fir_mac
  import gyro_filter_pkg::*;
#(
  parameter int DataWidth = 10,
  parameter int CoefWidth = 16,
  parameter int CoefFrac  = 15,
  parameter int Taps      = 10
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clr_i,
  input  logic                        en_i,
  input  logic                        last_i,
  input  logic signed [CoefWidth-1:0] coef_i,
  input  logic signed [DataWidth-1:0] sample_i,
  output logic signed [DataWidth-1:0] result_o
);

  localparam int ProdW = DataWidth + CoefWidth;
  // Headroom of $clog2(Taps) bits makes a full channel sum overflow-free.
  localparam int AccW  = ProdW + $clog2(Taps);

  logic signed [ProdW-1:0] prod;
  logic signed [AccW-1:0]  sum;
  logic signed [AccW-1:0]  acc_q;
  logic signed [AccW-1:0]  acc_d;
  logic signed [63:0]      rs;

  always_comb begin
    prod     = ProdW'(coef_i) * ProdW'(sample_i);
    sum      = acc_q + AccW'(prod);
    rs       = round_sat(64'(sum), CoefFrac, DataWidth);
    result_o = DataWidth'(rs);
  end

  // The last tap of a channel hands its sum to the output stage and
  // leaves the accumulator empty for the next channel.
  always_comb begin
    acc_d = acc_q;
    if (clr_i || (en_i && last_i)) acc_d = '0;
    else if (en_i)                 acc_d = sum;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) acc_q <= '0;
    else       acc_q <= acc_d;
  end

endmodule

// File: rtl/gyro_fir_filter.sv
// Time-multiplexed FIR filter for the IMU gyro path.
// One MAC engine walks every tap of every channel, then publishes all
// channels at once, so filtered_out never shows a partial set.
// Ports:
//   clk_i : sole clock, rising edge
//   rst_i : synchronous active-high reset (aborts any run in progress)
//   bus   : slave side of gyro_fir_filter_if (samples, coefficient writes,
//           bypass, overrun clear in; filtered data, data_ready, busy,
//           overrun out)
module gyro_fir_filter
  import gyro_filter_pkg::*;
#(
  parameter int DataWidth = 10,
  parameter int Channels  = 3,
  parameter int Taps      = 10,
  parameter int CoefWidth = 16,
  parameter int CoefFrac  = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  gyro_fir_filter_if.slave  bus
);

  localparam int TapW  = $clog2(Taps);
  localparam int ChanW = (Channels > 1) ? $clog2(Channels) : 1;

  logic signed [DataWidth-1:0] dly_q    [Channels][Taps];
  logic signed [DataWidth-1:0] shadow_q [Channels];
  logic signed [CoefWidth-1:0] coef_q   [Taps];
  logic [Channels*DataWidth-1:0] out_q;

  state_e            state_q, state_d;
  logic [ChanW-1:0]  chan_q, chan_d;
  logic [TapW-1:0]   tap_q, tap_d;
  logic              byp_q, byp_d;
  logic              ready_q;
  logic              ovr_q;

  logic              accept;
  logic              drop;
  logic              mac_en;
  logic              mac_last;
  logic              done;
  logic              tap_last;
  logic              chan_last;
  logic              coef_wr_ok;
  logic signed [DataWidth-1:0] mac_res;

  assign tap_last   = (tap_q == TapW'(Taps - 1));
  assign chan_last  = (chan_q == ChanW'(Channels - 1));
  assign drop       = bus.sample_valid && (state_q != IDLE);
  // Coefficients may only change between runs; out-of-range taps are ignored.
  assign coef_wr_ok = bus.coef_write && (state_q == IDLE) &&
                      ({1'b0, bus.coef_addr} < (TapW + 1)'(Taps));

  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    tap_d    = tap_q;
    byp_d    = byp_q;
    accept   = 1'b0;
    mac_en   = 1'b0;
    mac_last = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.sample_valid) begin
          accept  = 1'b1;
          byp_d   = bus.bypass;
          chan_d  = '0;
          tap_d   = '0;
          state_d = bus.bypass ? DONE : MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (tap_last) begin
          mac_last = 1'b1;
          tap_d    = '0;
          if (chan_last) state_d = DONE;
          else           chan_d  = chan_q + ChanW'(1);
        end else begin
          tap_d = tap_q + TapW'(1);
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  fir_mac #(
    .DataWidth (DataWidth),
    .CoefWidth (CoefWidth),
    .CoefFrac  (CoefFrac),
    .Taps      (Taps)
  ) u_mac (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (accept),
    .en_i     (mac_en),
    .last_i   (mac_last),
    .coef_i   (coef_q[tap_q]),
    .sample_i (dly_q[chan_q][tap_q]),
    .result_o (mac_res)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      chan_q  <= '0;
      tap_q   <= '0;
      byp_q   <= 1'b0;
      ready_q <= 1'b0;
      ovr_q   <= 1'b0;
      out_q   <= '0;
      for (int c = 0; c < Channels; c++) begin
        shadow_q[c] <= '0;
        for (int k = 0; k < Taps; k++) dly_q[c][k] <= '0;
      end
      for (int k = 0; k < Taps; k++) coef_q[k] <= CoefWidth'(default_coef(k));
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      tap_q   <= tap_d;
      byp_q   <= byp_d;
      ready_q <= done;

      if (coef_wr_ok) coef_q[bus.coef_addr] <= $signed(bus.coef_data);

      // Bypassed sets still enter the history so filtering resumes cleanly.
      if (accept) begin
        for (int c = 0; c < Channels; c++) begin
          for (int k = Taps - 1; k > 0; k--) dly_q[c][k] <= dly_q[c][k-1];
          dly_q[c][0] <= $signed(bus.sample_in[c*DataWidth +: DataWidth]);
        end
      end

      if (mac_last) shadow_q[chan_q] <= mac_res;

      if (done) begin
        for (int c = 0; c < Channels; c++)
          out_q[c*DataWidth +: DataWidth] <= byp_q ? dly_q[c][0] : shadow_q[c];
      end

      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)                   ovr_q <= 1'b1;
      else if (bus.overrun_clear) ovr_q <= 1'b0;
    end
  end

  assign bus.filtered_out = out_q;
  assign bus.data_ready   = ready_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.overrun      = ovr_q;

endmodule

// File: tb/tb_gyro_fir_filter.sv
module tb_gyro_fir_filter;
  localparam int DW = 10;
  localparam int CH = 3;
  localparam int TP = 10;
  localparam int CW = 16;
  localparam int CF = 15;
  localparam int FILT_LAT = CH * TP + 1;
  localparam int BYP_LAT  = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gyro_fir_filter_if #(.DataWidth(DW), .Channels(CH), .Taps(TP), .CoefWidth(CW)) bus();

  gyro_fir_filter #(.DataWidth(DW), .Channels(CH), .Taps(TP), .CoefWidth(CW), .CoefFrac(CF))
    dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  localparam logic [15:0] DEF [10] = '{16'hfda5, 16'h0e32, 16'hd54b, 16'h52ed, 16'h8e58,
                                        16'h71a8, 16'had13, 16'h2ab5, 16'hf1ce, 16'h025b};

  typedef struct packed {
    logic [CH-1:0][31:0] v;
    logic [31:0]         e;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   ready_edge;
  int   coef_m [TP];
  int   hist_m [CH][TP];
  bit   ovr_m;
  logic signed [DW-1:0] got;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    bus.sample_valid  = 1'b0;
    bus.sample_in     = '0;
    bus.bypass        = 1'b0;
    bus.coef_write    = 1'b0;
    bus.coef_addr     = '0;
    bus.coef_data     = '0;
    bus.overrun_clear = 1'b0;
  endtask

  task automatic reset_model();
    for (int k = 0; k < TP; k++) coef_m[k] = int'($signed(DEF[k]));
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < TP; k++) hist_m[c][k] = 0;
    ovr_m = 1'b0;
    ready_edge = -100;
    sb.delete();
  endtask

  // Reference: plain dot product, round half up via floor division, clamp.
  function automatic int filt(input int c);
    longint acc;
    longint r;
    longint q;
    longint den;
    acc = 0;
    den = longint'(1) << CF;
    for (int k = 0; k < TP; k++) acc += longint'(coef_m[k]) * longint'(hist_m[c][k]);
    r = acc + den / 2;
    q = r / den;
    if (r < 0 && (r % den) != 0) q = q - 1;
    if (q > 511) q = 511;
    if (q < -512) q = -512;
    return int'(q);
  endfunction

  task automatic dut_reset();
    rst = 1'b1;
    idle_inputs();
    sb.delete();
    tick();
    tick();
    reset_model();
    rst = 1'b0;
  endtask

  task automatic send(input int s0, input int s1, input int s2, input bit byp,
                      input bit clr, input bit cw, input int ca, input int cd);
    int   s [CH];
    bit   idle;
    exp_t ne;
    s[0] = s0; s[1] = s1; s[2] = s2;
    bus.sample_valid  = 1'b1;
    bus.sample_in     = {DW'(s2), DW'(s1), DW'(s0)};
    bus.bypass        = byp;
    bus.overrun_clear = clr;
    bus.coef_write    = cw;
    bus.coef_addr     = 4'(ca);
    bus.coef_data     = 16'(cd);
    tick();
    idle = (cyc > ready_edge);
    if (cw && idle) coef_m[ca] = cd;
    if (idle) begin
      for (int c = 0; c < CH; c++) begin
        for (int k = TP - 1; k > 0; k--) hist_m[c][k] = hist_m[c][k-1];
        hist_m[c][0] = s[c];
      end
      for (int c = 0; c < CH; c++) ne.v[c] = 32'(byp ? s[c] : filt(c));
      ne.e = 32'(cyc + (byp ? BYP_LAT : FILT_LAT));
      ready_edge = cyc + (byp ? BYP_LAT : FILT_LAT);
      sb.push_back(ne);
    end else begin
      ovr_m = 1'b1;
    end
    if (idle && clr) ovr_m = 1'b0;
    idle_inputs();
  endtask

  task automatic write_coef(input int a, input int d);
    bus.coef_write = 1'b1;
    bus.coef_addr  = 4'(a);
    bus.coef_data  = 16'(d);
    tick();
    if (cyc > ready_edge) coef_m[a] = d;
    idle_inputs();
  endtask

  task automatic clear_ovr();
    bus.overrun_clear = 1'b1;
    tick();
    ovr_m = 1'b0;
    idle_inputs();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain timeout pending", sb.size(), 0);
      sb.delete();
    end
    tick();
  endtask

  task automatic load_coefs(input int c0, input int c1);
    write_coef(0, c0);
    write_coef(1, c1);
    for (int k = 2; k < TP; k++) write_coef(k, 0);
  endtask

  task automatic run1(input int s0, input int s1, input int s2);
    send(s0, s1, s2, 0, 0, 0, 0, 0);
    wait_idle(60);
  endtask

  // Monitor: every DataReady pops one expected set and checks data and latency.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.data_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected data_ready", 1, 0);
      end else begin
        me = sb.pop_front();
        chk("ready latency edge", cyc, longint'(me.e));
        for (int c = 0; c < CH; c++) begin
          got = bus.filtered_out[c*DW +: DW];
          chk($sformatf("out ch%0d", c), longint'(got), longint'($signed(me.v[c])));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    reset_model();
    tick();
    tick();
    chk("reset filtered_out", longint'(bus.filtered_out), 0);
    chk("reset data_ready", longint'(bus.data_ready), 0);
    chk("reset busy", longint'(bus.busy), 0);
    chk("reset overrun", longint'(bus.overrun), 0);
    rst = 1'b0;

    // DC rejection with default coefficients
    for (int i = 0; i < 12; i++) begin
      send(200, 200, 200, 0, 0, 0, 0, 0);
      if (i == 0) chk("busy after accept", longint'(bus.busy), 1);
      wait_idle(60);
    end
    chk("dc final out", longint'(bus.filtered_out), 0);

    // Random coefficients and samples, occasional bypass
    for (int r = 0; r < 6; r++) begin
      for (int w = 0; w < 3; w++)
        write_coef(int'($urandom_range(0, TP - 1)), int'($urandom_range(0, 65535)) - 32768);
      for (int i = 0; i < 4; i++) begin
        send(int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 1023)) - 512,
             int'($urandom_range(0, 1023)) - 512, ($urandom_range(0, 4) == 0), 0, 0, 0, 0);
        wait_idle(60);
      end
    end

    // Moving average
    dut_reset();
    load_coefs(16384, 16384);
    run1(100, 0, 0);
    run1(0, 0, 0);
    run1(0, 0, 0);

    // Rounding and saturation
    dut_reset();
    load_coefs(16384, 16384);
    run1(3, 3, 3);
    run1(3, 3, 3);
    dut_reset();
    load_coefs(16384, 16384);
    run1(-3, -3, -3);
    load_coefs(32767, 32767);
    run1(511, 511, 511);
    run1(511, 511, 511);
    run1(-512, -512, -512);
    run1(-512, -512, -512);

    // Same-cycle coefficient write and sample: write lands first
    send(5, 6, 7, 0, 0, 1, 0, 8000);
    wait_idle(60);

    // Overrun: drop mid-MAC, delay line and coefficients untouched
    send(10, 20, 30, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick();
    send(99, 99, 99, 0, 0, 1, 2, 1000);
    chk("overrun set", longint'(bus.overrun), longint'(ovr_m));
    wait_idle(60);
    run1(1, 2, 3);
    clear_ovr();
    chk("overrun cleared", longint'(bus.overrun), longint'(ovr_m));
    send(4, 5, 6, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    send(77, 77, 77, 0, 1, 0, 0, 0);
    chk("overrun set wins", longint'(bus.overrun), 1);
    wait_idle(60);
    clear_ovr();

    // Bypass, then a filtered run that sees the bypassed sample
    send(7, -8, 9, 1, 0, 0, 0, 0);
    wait_idle(10);
    chk("bypass held out", longint'(bus.filtered_out), longint'({10'(9), 10'(-8), 10'(7)}));
    run1(0, 0, 0);
    run1(0, 0, 0);

    // Reset mid-MAC: no DataReady, outputs zero, defaults back
    write_coef(0, 12345);
    send(100, -100, 50, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick();
    write_coef(1, 777);
    dut_reset();
    chk("midreset filtered_out", longint'(bus.filtered_out), 0);
    chk("midreset busy", longint'(bus.busy), 0);
    chk("midreset overrun", longint'(bus.overrun), 0);
    for (int i = 0; i < 40; i++) tick();
    chk("midreset data_ready", longint'(bus.data_ready), 0);
    run1(100, 100, 100);
    run1(0, 0, 0);
    run1(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
